// File: rtl/ysyx_23060025_axi_arbiter_rr_pkg.sv
// Shared definitions for the N-master round-robin AXI4 arbiter:
// burst/response codes, fixed master IDs and the read/write FSM state types.
package ysyx_23060025_axi_arbiter_rr_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int ID_IF  = 0;
   localparam int ID_LSU = 1;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_DATA
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_REQ,
      W_RESP
   } w_state_e;

endpackage

// File: rtl/ysyx_23060025_axi_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first asserted request
// strictly after the pointer, wrapping around, as one-hot plus index.
module ysyx_23060025_rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = ptr;
      // Walk N candidates starting at ptr+1 so the last winner is checked last.
      for (int k = 0; k < N; k++) begin
         cand = (cand == LAST) ? '0 : cand + 1'b1;
         if (!found && req[cand]) begin
            found     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ysyx_23060025_axi_arbiter_rr.sv
// N-master to 1-slave AXI4 arbiter with independent round-robin read and
// write FSMs; the grant is held for a whole burst and the ID equals the index.
module ysyx_23060025_axi_arbiter_rr
   import ysyx_23060025_axi_arbiter_rr_pkg::*;
#(
   parameter int NUM_MST  = 2,
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32,
   parameter int ID_W     = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_MST-1:0]             m_arvalid,
   output logic [NUM_MST-1:0]             m_arready,
   input  logic [NUM_MST*ADDR_LEN-1:0]    m_araddr,
   input  logic [NUM_MST*8-1:0]           m_arlen,
   input  logic [NUM_MST*3-1:0]           m_arsize,
   output logic [NUM_MST-1:0]             m_rvalid,
   output logic [NUM_MST-1:0]             m_rlast,
   input  logic [NUM_MST-1:0]             m_rready,
   output logic [DATA_LEN-1:0]            m_rdata,
   output logic [1:0]                     m_rresp,
   input  logic [NUM_MST-1:0]             m_awvalid,
   output logic [NUM_MST-1:0]             m_awready,
   input  logic [NUM_MST*ADDR_LEN-1:0]    m_awaddr,
   input  logic [NUM_MST*8-1:0]           m_awlen,
   input  logic [NUM_MST*3-1:0]           m_awsize,
   input  logic [NUM_MST-1:0]             m_wvalid,
   input  logic [NUM_MST-1:0]             m_wlast,
   output logic [NUM_MST-1:0]             m_wready,
   input  logic [NUM_MST*DATA_LEN-1:0]    m_wdata,
   input  logic [NUM_MST*DATA_LEN/8-1:0]  m_wstrb,
   output logic [NUM_MST-1:0]             m_bvalid,
   output logic [1:0]                     m_bresp,
   input  logic [NUM_MST-1:0]             m_bready,
   output logic                           s_arvalid,
   input  logic                           s_arready,
   output logic [ID_W-1:0]                s_arid,
   output logic [ADDR_LEN-1:0]            s_araddr,
   output logic [7:0]                     s_arlen,
   output logic [2:0]                     s_arsize,
   output logic [1:0]                     s_arburst,
   input  logic                           s_rvalid,
   output logic                           s_rready,
   input  logic [ID_W-1:0]                s_rid,
   input  logic [DATA_LEN-1:0]            s_rdata,
   input  logic [1:0]                     s_rresp,
   input  logic                           s_rlast,
   output logic                           s_awvalid,
   input  logic                           s_awready,
   output logic [ID_W-1:0]                s_awid,
   output logic [ADDR_LEN-1:0]            s_awaddr,
   output logic [7:0]                     s_awlen,
   output logic [2:0]                     s_awsize,
   output logic [1:0]                     s_awburst,
   output logic                           s_wvalid,
   input  logic                           s_wready,
   output logic [DATA_LEN-1:0]            s_wdata,
   output logic [DATA_LEN/8-1:0]          s_wstrb,
   output logic                           s_wlast,
   input  logic                           s_bvalid,
   output logic                           s_bready,
   input  logic [ID_W-1:0]                s_bid,
   input  logic [1:0]                     s_bresp,
   output logic                           id_err
);

   localparam int IDX_W  = $clog2(NUM_MST);
   localparam int STRB_W = DATA_LEN / 8;

   logic [ADDR_LEN-1:0] ar_addr_a [NUM_MST];
   logic [7:0]          ar_len_a  [NUM_MST];
   logic [2:0]          ar_size_a [NUM_MST];
   logic [ADDR_LEN-1:0] aw_addr_a [NUM_MST];
   logic [7:0]          aw_len_a  [NUM_MST];
   logic [2:0]          aw_size_a [NUM_MST];
   logic [DATA_LEN-1:0] w_data_a  [NUM_MST];
   logic [STRB_W-1:0]   w_strb_a  [NUM_MST];

   for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
      assign ar_addr_a[i] = m_araddr[i*ADDR_LEN +: ADDR_LEN];
      assign ar_len_a[i]  = m_arlen[i*8 +: 8];
      assign ar_size_a[i] = m_arsize[i*3 +: 3];
      assign aw_addr_a[i] = m_awaddr[i*ADDR_LEN +: ADDR_LEN];
      assign aw_len_a[i]  = m_awlen[i*8 +: 8];
      assign aw_size_a[i] = m_awsize[i*3 +: 3];
      assign w_data_a[i]  = m_wdata[i*DATA_LEN +: DATA_LEN];
      assign w_strb_a[i]  = m_wstrb[i*STRB_W +: STRB_W];
   end

   r_state_e         r_state_q, r_state_d;
   logic [IDX_W-1:0] r_gnt_q, r_gnt_d;
   logic [IDX_W-1:0] r_ptr_q, r_ptr_d;
   w_state_e         w_state_q, w_state_d;
   logic [IDX_W-1:0] w_gnt_q, w_gnt_d;
   logic [IDX_W-1:0] w_ptr_q, w_ptr_d;
   logic             aw_done_q, aw_done_d;
   logic             w_done_q, w_done_d;
   logic             id_err_q, id_err_d;

   logic [NUM_MST-1:0] r_pick_gnt, w_pick_gnt;
   logic [IDX_W-1:0]   r_pick_idx, w_pick_idx;
   logic               r_hs, b_hs, aw_fire, w_last_fire;

   ysyx_23060025_rr_picker #(.N(NUM_MST), .IDX_W(IDX_W)) u_r_pick (
      .req (m_arvalid),
      .ptr (r_ptr_q),
      .gnt (r_pick_gnt),
      .idx (r_pick_idx)
   );

   ysyx_23060025_rr_picker #(.N(NUM_MST), .IDX_W(IDX_W)) u_w_pick (
      .req (m_awvalid),
      .ptr (w_ptr_q),
      .gnt (w_pick_gnt),
      .idx (w_pick_idx)
   );

   // Slave-side payload always follows the registered grant; valids gate it.
   assign s_arid    = ID_W'(r_gnt_q);
   assign s_araddr  = ar_addr_a[r_gnt_q];
   assign s_arlen   = ar_len_a[r_gnt_q];
   assign s_arsize  = ar_size_a[r_gnt_q];
   assign s_arburst = BURST_INCR;
   assign s_awid    = ID_W'(w_gnt_q);
   assign s_awaddr  = aw_addr_a[w_gnt_q];
   assign s_awlen   = aw_len_a[w_gnt_q];
   assign s_awsize  = aw_size_a[w_gnt_q];
   assign s_awburst = BURST_INCR;
   assign s_wdata   = w_data_a[w_gnt_q];
   assign s_wstrb   = w_strb_a[w_gnt_q];
   assign s_wlast   = m_wlast[w_gnt_q];
   assign m_rdata   = s_rdata;
   assign m_rresp   = s_rresp;
   assign m_bresp   = s_bresp;
   assign id_err    = id_err_q;

   always_comb begin
      r_state_d = r_state_q;
      r_gnt_d   = r_gnt_q;
      r_ptr_d   = r_ptr_q;
      s_arvalid = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      m_rlast   = '0;
      s_rready  = 1'b0;
      r_hs      = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (|r_pick_gnt) begin
               r_gnt_d   = r_pick_idx;
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            s_arvalid          = m_arvalid[r_gnt_q];
            m_arready[r_gnt_q] = s_arready;
            if (m_arvalid[r_gnt_q] && s_arready) r_state_d = R_DATA;
         end
         R_DATA: begin
            m_rvalid[r_gnt_q] = s_rvalid;
            m_rlast[r_gnt_q]  = s_rlast;
            s_rready          = m_rready[r_gnt_q];
            r_hs              = s_rvalid && m_rready[r_gnt_q];
            if (r_hs && s_rlast) begin
               r_state_d = R_IDLE;
               r_ptr_d   = r_gnt_q;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d   = w_state_q;
      w_gnt_d     = w_gnt_q;
      w_ptr_d     = w_ptr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      s_awvalid   = 1'b0;
      m_awready   = '0;
      s_wvalid    = 1'b0;
      m_wready    = '0;
      m_bvalid    = '0;
      s_bready    = 1'b0;
      aw_fire     = 1'b0;
      w_last_fire = 1'b0;
      b_hs        = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (|w_pick_gnt) begin
               w_gnt_d   = w_pick_idx;
               w_state_d = W_REQ;
            end
         end
         W_REQ: begin
            // AW and W finish independently; each side goes quiet once done.
            s_awvalid          = m_awvalid[w_gnt_q] && !aw_done_q;
            m_awready[w_gnt_q] = s_awready && !aw_done_q;
            s_wvalid           = m_wvalid[w_gnt_q] && !w_done_q;
            m_wready[w_gnt_q]  = s_wready && !w_done_q;
            aw_fire            = s_awvalid && s_awready;
            w_last_fire        = s_wvalid && s_wready && m_wlast[w_gnt_q];
            if ((aw_done_q || aw_fire) && (w_done_q || w_last_fire)) begin
               w_state_d = W_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               aw_done_d = aw_done_q || aw_fire;
               w_done_d  = w_done_q || w_last_fire;
            end
         end
         W_RESP: begin
            m_bvalid[w_gnt_q] = s_bvalid;
            s_bready          = m_bready[w_gnt_q];
            b_hs              = s_bvalid && m_bready[w_gnt_q];
            if (b_hs) begin
               w_state_d = W_IDLE;
               w_ptr_d   = w_gnt_q;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign id_err_d = (r_hs && (s_rid != ID_W'(r_gnt_q))) ||
                     (b_hs && (s_bid != ID_W'(w_gnt_q)));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_gnt_q   <= '0;
         r_ptr_q   <= IDX_W'(NUM_MST - 1);
         w_state_q <= W_IDLE;
         w_gnt_q   <= '0;
         w_ptr_q   <= IDX_W'(NUM_MST - 1);
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         id_err_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_gnt_q   <= r_gnt_d;
         r_ptr_q   <= r_ptr_d;
         w_state_q <= w_state_d;
         w_gnt_q   <= w_gnt_d;
         w_ptr_q   <= w_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         id_err_q  <= id_err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter_rr.sv
// Directed bench for the round-robin AXI arbiter: inputs change and outputs
// are checked just after the falling edge; the bench plays the slave by hand.
module tb_ysyx_23060025_axi_arbiter_rr;
   import ysyx_23060025_axi_arbiter_rr_pkg::*;

   localparam int NM = 2;
   localparam int AL = 32;
   localparam int DL = 32;
   localparam int IW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [NM-1:0]      m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic [NM*AL-1:0]   m_araddr, m_awaddr;
   logic [NM*8-1:0]    m_arlen, m_awlen;
   logic [NM*3-1:0]    m_arsize, m_awsize;
   logic [DL-1:0]      m_rdata;
   logic [1:0]         m_rresp, m_bresp;
   logic [NM-1:0]      m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
   logic [NM*DL-1:0]   m_wdata;
   logic [NM*DL/8-1:0] m_wstrb;
   logic [NM-1:0]      m_bvalid, m_bready;
   logic               s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [IW-1:0]      s_arid, s_rid, s_awid, s_bid;
   logic [AL-1:0]      s_araddr, s_awaddr;
   logic [7:0]         s_arlen, s_awlen;
   logic [2:0]         s_arsize, s_awsize;
   logic [1:0]         s_arburst, s_awburst, s_rresp, s_bresp;
   logic [DL-1:0]      s_rdata, s_wdata;
   logic               s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic [DL/8-1:0]    s_wstrb;
   logic               s_bvalid, s_bready, id_err;

   ysyx_23060025_axi_arbiter_rr #(.NUM_MST(NM), .ADDR_LEN(AL), .DATA_LEN(DL), .ID_W(IW)) dut (
      .clock(clock), .reset(reset),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
      .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
      .id_err(id_err)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int beats  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_rready = '0;
      m_awvalid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
      m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

      step(); step(); settle();
      check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
      check("rst_m_handshakes", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 10'b0);
      check("rst_id_err", id_err, 1'b0);

      // T1: both masters request together; master 0 first
      step(); reset = 1'b0;
      m_arvalid = 2'b11; m_araddr = {32'h2000_0000, 32'h1000_0000};
      m_arlen = {8'd3, 8'd1}; m_arsize = {3'd2, 3'd1}; settle();
      check("t1_ar_latency", s_arvalid, 1'b0);
      step(); settle();
      check("t1_arvalid", s_arvalid, 1'b1);
      check("t1_arid", s_arid, 4'(ID_IF));
      check("t1_araddr", s_araddr, 32'h1000_0000);
      check("t1_arlen", s_arlen, 8'd1);
      check("t1_arsize", s_arsize, 3'd1);
      check("t1_arburst", s_arburst, BURST_INCR);
      check("t1_arready_wait", m_arready, 2'b00);
      s_arready = 1'b1; settle();
      check("t1_arready", m_arready, 2'b01);
      step(); m_arvalid = 2'b10; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'hA000_0000; s_rlast = 1'b0;
      s_rresp = RESP_OKAY; m_rready = 2'b01; settle();
      check("t1_rvalid", m_rvalid, 2'b01);
      check("t1_rdata", m_rdata, 32'hA000_0000);
      check("t1_rready", s_rready, 1'b1);
      check("t1_no_ar_in_data", {s_arvalid, m_arready}, 3'b0);
      step(); s_rdata = 32'hA000_0001; s_rlast = 1'b1; settle();
      check("t1_rlast", m_rlast, 2'b01);
      step(); s_rvalid = 1'b0; s_rlast = 1'b0; settle();
      check("t1_idle_after_last", {s_arvalid, m_rvalid}, 3'b0);
      check("t1_id_err_quiet", id_err, 1'b0);
      step(); settle();
      check("t1_m1_arvalid", s_arvalid, 1'b1);
      check("t1_m1_arid", s_arid, 4'(ID_LSU));
      check("t1_m1_araddr", s_araddr, 32'h2000_0000);
      check("t1_m1_arlen", s_arlen, 8'd3);

      // T2: master 1 four-beat burst, one beat stalled by the master
      s_arready = 1'b1; settle();
      check("t2_arready", m_arready, 2'b10);
      step(); m_arvalid = 2'b00; s_arready = 1'b0; m_rready = 2'b10; s_rid = 4'd1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            s_rvalid = 1'b1; s_rdata = 32'hB000_0002; s_rlast = 1'b0; m_rready = 2'b00; settle();
            check("t2_stall_rready", s_rready, 1'b0);
            check("t2_stall_rvalid", m_rvalid, 2'b10);
            step(); m_rready = 2'b10;
         end
         s_rvalid = 1'b1; s_rdata = 32'hB000_0000 + i; s_rlast = (i == 3); settle();
         check("t2_rvalid", m_rvalid, 2'b10);
         check("t2_rdata", m_rdata, 32'hB000_0000 + i);
         check("t2_rlast", m_rlast, (i == 3) ? 2'b10 : 2'b00);
         if (m_rvalid[1] && s_rready) beats++;
         step();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; settle();
      check("t2_beats", beats, 4);
      check("t2_idle", {s_arvalid, m_rvalid}, 3'b0);

      // T3: LSU write with W offered a cycle before AW
      m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata = {32'hCAFE_0001, 32'h0};
      m_wstrb = {4'hF, 4'h0}; s_wready = 1'b1; settle();
      check("t3_w_held", {s_wvalid, m_wready}, 3'b0);
      step(); settle();
      check("t3_w_not_request", {s_wvalid, s_awvalid}, 2'b0);
      m_awvalid = 2'b10; m_awaddr = {32'h3000_0000, 32'h0}; m_awlen = 16'h0; m_awsize = {3'd2, 3'd0}; settle();
      check("t3_aw_latency", s_awvalid, 1'b0);
      step(); settle();
      check("t3_awvalid", s_awvalid, 1'b1);
      check("t3_awid", s_awid, 4'(ID_LSU));
      check("t3_awaddr", s_awaddr, 32'h3000_0000);
      check("t3_awlen_size", {s_awlen, s_awsize}, {8'd0, 3'd2});
      check("t3_awburst", s_awburst, BURST_INCR);
      check("t3_wfwd", {s_wvalid, s_wlast, s_wstrb}, {1'b1, 1'b1, 4'hF});
      check("t3_wdata", s_wdata, 32'hCAFE_0001);
      check("t3_wready", m_wready, 2'b10);
      check("t3_awready_wait", m_awready, 2'b00);
      step(); s_awready = 1'b1; settle();
      check("t3_w_done_mask", {s_wvalid, m_wready}, 3'b0);
      check("t3_awready", m_awready, 2'b10);
      step(); m_awvalid = '0; m_wvalid = '0; m_wlast = '0; s_awready = 1'b0;
      s_bvalid = 1'b1; s_bid = 4'd1; s_bresp = RESP_OKAY; m_bready = 2'b10; settle();
      check("t3_bvalid", m_bvalid, 2'b10);
      check("t3_bresp", m_bresp, RESP_OKAY);
      check("t3_bready", s_bready, 1'b1);
      check("t3_aw_quiet", s_awvalid, 1'b0);
      step(); s_bvalid = 1'b0; settle();
      check("t3_b_idle", m_bvalid, 2'b00);
      check("t3_id_err", id_err, 1'b0);

      // T4: IFU read burst alongside LSU write; R last and B in the same cycle
      m_arvalid = 2'b01; m_araddr = {32'h0, 32'h4000_0000}; m_arlen = {8'd0, 8'd1}; s_arready = 1'b1;
      m_awvalid = 2'b10; m_awaddr = {32'h5000_0000, 32'h0}; m_awlen = '0;
      m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata = {32'h5555_0000, 32'h0}; s_awready = 1'b1;
      step(); settle();
      check("t4_fwd", {s_arvalid, s_awvalid, s_wvalid}, 3'b111);
      check("t4_readies", {m_arready, m_awready, m_wready}, 6'b01_10_10);
      check("t4_ids", {s_arid, s_awid}, {4'd0, 4'd1});
      step(); m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      s_arready = 1'b0; s_awready = 1'b0;
      s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'h4444_0000; s_rlast = 1'b0; m_rready = 2'b01;
      m_bready = 2'b10; settle();
      check("t4_beat0", {m_rvalid, m_bvalid}, 4'b01_00);
      step(); s_rdata = 32'h4444_0001; s_rlast = 1'b1; s_bvalid = 1'b1; s_bresp = RESP_SLVERR; settle();
      check("t4_both", {m_rvalid, m_rlast, m_bvalid}, 6'b01_01_10);
      check("t4_bresp", m_bresp, RESP_SLVERR);
      check("t4_slave_readies", {s_rready, s_bready}, 2'b11);
      step(); settle();
      check("t4_both_idle", {m_rvalid, m_bvalid, s_rready, s_bready}, 6'b0);
      s_rvalid = 1'b0; s_bvalid = 1'b0; s_rlast = 1'b0; s_bresp = RESP_OKAY;

      // T5: wrong s_rid while master 0 owns the read channel
      m_arvalid = 2'b01; m_araddr = {32'h0, 32'h6000_0000}; m_arlen = '0; s_arready = 1'b1;
      step(); settle();
      check("t5_arid", {s_arvalid, s_arid}, {1'b1, 4'd0});
      step(); m_arvalid = '0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd3; s_rdata = 32'hDEAD_BEEF;
      s_rresp = RESP_DECERR; m_rready = 2'b01; settle();
      check("t5_rvalid", m_rvalid, 2'b01);
      check("t5_rdata", m_rdata, 32'hDEAD_BEEF);
      check("t5_rresp", m_rresp, RESP_DECERR);
      check("t5_id_err_pre", id_err, 1'b0);
      step(); s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = RESP_OKAY; settle();
      check("t5_id_err_pulse", id_err, 1'b1);
      check("t5_no_stall", m_rvalid, 2'b00);
      step(); settle();
      check("t5_id_err_end", id_err, 1'b0);

      // T6: reset during beat 2 of a 4-beat read from master 1
      m_arvalid = 2'b10; m_araddr = {32'h7000_0000, 32'h0}; m_arlen = {8'd3, 8'd0}; s_arready = 1'b1;
      step(); settle();
      check("t6_arid", s_arid, 4'd1);
      step(); m_arvalid = '0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rid = 4'd1; s_rdata = 32'h7000_0000; s_rlast = 1'b0; m_rready = 2'b10;
      step(); s_rdata = 32'h7000_0001; reset = 1'b1; settle();
      check("t6_beat2_visible", m_rvalid, 2'b10);
      step(); settle();
      check("t6_rst_valids", {m_rvalid, s_rready, s_arvalid, s_awvalid, s_wvalid, m_bvalid}, 8'b0);
      check("t6_rst_id_err", id_err, 1'b0);
      reset = 1'b0; s_rvalid = 1'b0;
      m_arvalid = 2'b11; m_araddr = {32'h8000_0000, 32'h9000_0000}; m_arlen = '0; settle();
      check("t6_idle", s_arvalid, 1'b0);
      step(); settle();
      check("t6_ptr_reset", {s_arvalid, s_arid}, {1'b1, 4'd0});
      check("t6_araddr", s_araddr, 32'h9000_0000);
      s_arready = 1'b1;
      step(); m_arvalid = 2'b10; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd0; m_rready = 2'b01;
      step(); s_rvalid = 1'b0; s_rlast = 1'b0;
      step(); settle();
      check("t6_fair_next", {s_arvalid, s_arid}, {1'b1, 4'd1});

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
